// File: rtl/pe_array_ctrl_if.sv
// Handshake/strobe bundle between the tile scheduler, the PE-array controller and the array.
// The master side is the scheduler/buffers; the slave side is pe_array_ctrl.
interface pe_array_ctrl_if #(
   parameter int COL_W = 8
);
   logic             start;
   logic [COL_W-1:0] cfg_cols;
   logic             cfg_psum;
   logic             busy;
   logic             done;
   logic             wht_valid;
   logic             wht_ready;
   logic             ifm_valid;
   logic             ifm_ready;
   logic             psum_valid;
   logic             psum_ready;
   logic             res_valid;
   logic             res_ready;
   logic             wht_i_valid;
   logic             wht_i_ready;
   logic             if_i_valid;
   logic             if_i_ready;
   logic             psum_i_valid;
   logic             psum_i_ready;
   logic             reg_sft_en;
   logic             psum_acc_start;
   logic             acc_rst;
   logic             mul_une;
   logic             add_une;
   logic             out_ready;

   modport master (
      output start, cfg_cols, cfg_psum, wht_valid, ifm_valid, psum_valid, res_ready,
      input  busy, done, wht_ready, ifm_ready, psum_ready, res_valid,
             wht_i_valid, wht_i_ready, if_i_valid, if_i_ready, psum_i_valid, psum_i_ready,
             reg_sft_en, psum_acc_start, acc_rst, mul_une, add_une, out_ready
   );

   modport slave (
      input  start, cfg_cols, cfg_psum, wht_valid, ifm_valid, psum_valid, res_ready,
      output busy, done, wht_ready, ifm_ready, psum_ready, res_valid,
             wht_i_valid, wht_i_ready, if_i_valid, if_i_ready, psum_i_valid, psum_i_ready,
             reg_sft_en, psum_acc_start, acc_rst, mul_une, add_une, out_ready
   );
endinterface

// File: rtl/pe_array_ctrl.sv
// PE-array tile sequencer: weight load, per-column clear/ifm feed/psum/drain/result, done pulse.
// Optional PE_CTRL_UNIT_GATE_EN: gate multiplier/adder enables to the cycles that actually compute.
module pe_array_ctrl #(
   parameter int CHANNELS    = 4,
   parameter int KERNEL_SIZE = 3,
   parameter int PIPE_LAT    = 2,
   parameter int COL_W       = 8
) (
   input  logic         clk,
   input  logic         rst,
   pe_array_ctrl_if.slave bus
);
   localparam int NB   = CHANNELS * KERNEL_SIZE;
   localparam int BMAX = (NB > PIPE_LAT) ? NB : PIPE_LAT;
   localparam int BW   = $clog2(BMAX) + 1;
   localparam logic [BW-1:0] BEAT_LAST  = BW'(NB - 1);
   localparam logic [BW-1:0] PSUM_LAST  = BW'(KERNEL_SIZE - 1);
   localparam logic [BW-1:0] DRAIN_LAST = BW'(PIPE_LAT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WLOAD = 3'd1;
   localparam logic [2:0] S_CLR   = 3'd2;
   localparam logic [2:0] S_FEED  = 3'd3;
   localparam logic [2:0] S_PSUM  = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam logic [2:0] S_OUT   = 3'd6;
   localparam logic [2:0] S_FIN   = 3'd7;

   logic [2:0]       state;
   logic [BW-1:0]    beat_cnt;
   logic [COL_W-1:0] col_cnt;
   logic [COL_W-1:0] cols_q;
   logic             psum_q;
   logic             wht_acc, ifm_acc, psum_acc, res_acc;

   // Readies come from state only, so accepts never form a valid->ready loop.
   assign wht_acc  = (state == S_WLOAD) & bus.wht_valid;
   assign ifm_acc  = (state == S_FEED)  & bus.ifm_valid;
   assign psum_acc = (state == S_PSUM)  & bus.psum_valid;
   assign res_acc  = (state == S_OUT)   & bus.res_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         beat_cnt <= '0;
         col_cnt  <= '0;
         cols_q   <= '0;
         psum_q   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (bus.start) begin
               cols_q   <= (bus.cfg_cols == '0) ? COL_W'(1) : bus.cfg_cols;
               psum_q   <= bus.cfg_psum;
               col_cnt  <= '0;
               beat_cnt <= '0;
               state    <= S_WLOAD;
            end
            S_WLOAD: if (wht_acc) begin
               if (beat_cnt == BEAT_LAST) begin
                  beat_cnt <= '0;
                  state    <= S_CLR;
               end else beat_cnt <= beat_cnt + BW'(1);
            end
            S_CLR: begin
               beat_cnt <= '0;
               state    <= S_FEED;
            end
            S_FEED: if (ifm_acc) begin
               if (beat_cnt == BEAT_LAST) begin
                  beat_cnt <= '0;
                  state    <= psum_q ? S_PSUM : S_DRAIN;
               end else beat_cnt <= beat_cnt + BW'(1);
            end
            S_PSUM: if (psum_acc) begin
               if (beat_cnt == PSUM_LAST) begin
                  beat_cnt <= '0;
                  state    <= S_DRAIN;
               end else beat_cnt <= beat_cnt + BW'(1);
            end
            S_DRAIN: begin
               if (beat_cnt == DRAIN_LAST) begin
                  beat_cnt <= '0;
                  state    <= S_OUT;
               end else beat_cnt <= beat_cnt + BW'(1);
            end
            // Next column reuses the loaded weights: back to CLR, not WLOAD.
            S_OUT: if (res_acc) begin
               if (col_cnt == cols_q - COL_W'(1)) state <= S_FIN;
               else begin
                  col_cnt <= col_cnt + COL_W'(1);
                  state   <= S_CLR;
               end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy           = (state != S_IDLE);
   assign bus.done           = (state == S_FIN);
   assign bus.wht_ready      = (state == S_WLOAD);
   assign bus.ifm_ready      = (state == S_FEED);
   assign bus.psum_ready     = (state == S_PSUM);
   assign bus.res_valid      = (state == S_OUT);
   assign bus.wht_i_valid    = wht_acc;
   assign bus.wht_i_ready    = bus.wht_ready;
   assign bus.if_i_valid     = ifm_acc;
   assign bus.if_i_ready     = bus.ifm_ready;
   assign bus.psum_i_valid   = psum_acc;
   assign bus.psum_i_ready   = bus.psum_ready;
   assign bus.reg_sft_en     = ifm_acc;
   assign bus.psum_acc_start = ifm_acc & (beat_cnt == '0);
   assign bus.acc_rst        = (state == S_CLR);
   assign bus.out_ready      = res_acc;

`ifdef PE_CTRL_UNIT_GATE_EN
   assign bus.mul_une = ifm_acc | psum_acc | (state == S_DRAIN);
   assign bus.add_une = bus.mul_une | bus.acc_rst;
`else
   assign bus.mul_une = bus.busy;
   assign bus.add_une = bus.busy;
`endif
endmodule
